// File: rtl/cf_sweep_driver_if.sv
// Drive, capture and result bundle between cf_sweep_driver (master) and the
// environment hosting the CF_ block (slave). mismatch/mismatch_idx exist only with CF_SWEEP_CHECK_EN.
interface cf_sweep_driver_if;
    logic        start;
    logic        y;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        e;
    logic        busy;
    logic        done;
    logic [31:0] truth_table;
    logic [5:0]  ones_count;
`ifdef CF_SWEEP_CHECK_EN
    logic        mismatch;
    logic [4:0]  mismatch_idx;

    modport master (
        input  start, y,
        output a, b, c, d, e, busy, done, truth_table, ones_count, mismatch, mismatch_idx
    );
    modport slave (
        output start, y,
        input  a, b, c, d, e, busy, done, truth_table, ones_count, mismatch, mismatch_idx
    );
`else
    modport master (
        input  start, y,
        output a, b, c, d, e, busy, done, truth_table, ones_count
    );
    modport slave (
        output start, y,
        input  a, b, c, d, e, busy, done, truth_table, ones_count
    );
`endif
endinterface

// File: rtl/cf_sweep_driver.sv
// Exhaustive 32-vector sweep driver and truth-table capture for CF_ blocks.
// Optional golden compare is enabled by defining CF_SWEEP_CHECK_EN.
module cf_sweep_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
`ifdef CF_SWEEP_CHECK_EN
    , parameter logic [31:0] EXPECTED = 32'hFFFF_111F
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    cf_sweep_driver_if.master  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(SETTLE_CYCLES - 1);

    state_t      state_r;
    logic [4:0]  index_r;
    logic [3:0]  count_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] truth_table_r;
    logic [5:0]  ones_count_r;
`ifdef CF_SWEEP_CHECK_EN
    logic        mismatch_r;
    logic [4:0]  mismatch_idx_r;
`endif

    // Sweep sequencer: index doubles as the drive vector and rests at 0 while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            index_r        <= 5'd0;
            count_r        <= 4'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            truth_table_r  <= 32'd0;
            ones_count_r   <= 6'd0;
`ifdef CF_SWEEP_CHECK_EN
            mismatch_r     <= 1'b0;
            mismatch_idx_r <= 5'd0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r        <= SETTLE;
                        busy_r         <= 1'b1;
                        index_r        <= 5'd0;
                        count_r        <= 4'd0;
                        truth_table_r  <= 32'd0;
                        ones_count_r   <= 6'd0;
`ifdef CF_SWEEP_CHECK_EN
                        mismatch_r     <= 1'b0;
                        mismatch_idx_r <= 5'd0;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        index_r <= 5'd0;
                        count_r <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (count_r == LAST_COUNT) begin
                        truth_table_r[index_r] <= bus.y;
                        ones_count_r           <= ones_count_r + {5'd0, bus.y};
                        count_r                <= 4'd0;
`ifdef CF_SWEEP_CHECK_EN
                        // Only the first disagreement is recorded.
                        if ((bus.y != EXPECTED[index_r]) && !mismatch_r) begin
                            mismatch_r     <= 1'b1;
                            mismatch_idx_r <= index_r;
                        end else begin
                            mismatch_r     <= mismatch_r;
                        end
`endif
                        if (index_r == 5'd31) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            index_r <= 5'd0;
                        end else begin
                            index_r <= index_r + 5'd1;
                        end
                    end else begin
                        count_r <= count_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    index_r <= 5'd0;
                    count_r <= 4'd0;
                end
            endcase
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d, bus.e} = index_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.truth_table = truth_table_r;
    assign bus.ones_count  = ones_count_r;
`ifdef CF_SWEEP_CHECK_EN
    assign bus.mismatch     = mismatch_r;
    assign bus.mismatch_idx = mismatch_idx_r;
`endif

endmodule

// File: tb/tb_cf_sweep_driver.sv
// Scoreboard bench for cf_sweep_driver: S=1 and S=3 instances, each driving a
// table-defined stand-in for the downstream CF_ block.
module tb_cf_sweep_driver;
    localparam logic [31:0] GOLD = 32'hFFFF_111F;

    typedef struct packed {
        logic [31:0] tt;
        logic [5:0]  ones;
        logic        mm;
        logic [4:0]  idx;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] fn1 = GOLD;
    logic [31:0] fn3 = GOLD;

    exp_t        rq1[$];
    exp_t        rq3[$];
    logic [4:0]  vq1[$];
    logic [4:0]  vq3[$];

    cf_sweep_driver_if if1();
    cf_sweep_driver_if if3();

    cf_sweep_driver #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    cf_sweep_driver #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if1.y = fn1[{if1.a, if1.b, if1.c, if1.d, if1.e}];
    assign if3.y = fn3[{if3.a, if3.b, if3.c, if3.d, if3.e}];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] fn, input int e0, input int s);
        exp_t r;
        r.tt = fn;
        r.ones = 6'd0;
        r.mm = 1'b0;
        r.idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            r.ones = r.ones + {5'd0, fn[i]};
            if (!r.mm && (fn[i] != GOLD[i])) begin
                r.mm = 1'b1;
                r.idx = 5'(i);
            end
        end
        r.done_cyc = e0 + 32 * s;
        return r;
    endfunction

    task automatic push_sweep(input bit sel, input logic [31:0] fn, input int e0);
        int s;
        s = sel ? 3 : 1;
        if (sel) rq3.push_back(model(fn, e0, s));
        else     rq1.push_back(model(fn, e0, s));
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < s; j++) begin
                if (sel) vq3.push_back(5'(k));
                else     vq1.push_back(5'(k));
            end
        end
    endtask

    task automatic mon_one(input bit sel, input logic busy, input logic done, input logic [4:0] vec,
                           input logic [31:0] tt, input logic [5:0] ones,
                           input logic mm, input logic [4:0] idx);
        exp_t       ex;
        logic [4:0] v;
        int         vn;
        int         rn;
        vn = sel ? vq3.size() : vq1.size();
        rn = sel ? rq3.size() : rq1.size();
        if (busy) begin
            if (vn == 0) check_val(sel ? "busy_len3" : "busy_len1", {63'd0, busy}, 64'd0);
            else begin
                if (sel) v = vq3.pop_front();
                else     v = vq1.pop_front();
                check_val(sel ? "vec3" : "vec1", {59'd0, vec}, {59'd0, v});
            end
        end
        if (done) begin
            if (rn == 0) check_val(sel ? "spurious_done3" : "spurious_done1", {63'd0, done}, 64'd0);
            else begin
                if (sel) ex = rq3.pop_front();
                else     ex = rq1.pop_front();
                check_val("done_cycle", 64'(cyc), 64'(ex.done_cyc));
                check_val("truth_table", {32'd0, tt}, {32'd0, ex.tt});
                check_val("ones_count", {58'd0, ones}, {58'd0, ex.ones});
                check_val("busy_at_done", {63'd0, busy}, 64'd0);
                check_val("vec_at_done", {59'd0, vec}, 64'd0);
`ifdef CF_SWEEP_CHECK_EN
                check_val("mismatch", {63'd0, mm}, {63'd0, ex.mm});
                check_val("mismatch_idx", {59'd0, idx}, {59'd0, ex.idx});
`endif
            end
        end
    endtask

    logic       mm1_s, mm3_s;
    logic [4:0] idx1_s, idx3_s;
`ifdef CF_SWEEP_CHECK_EN
    assign mm1_s = if1.mismatch;
    assign mm3_s = if3.mismatch;
    assign idx1_s = if1.mismatch_idx;
    assign idx3_s = if3.mismatch_idx;
`else
    assign mm1_s = 1'b0;
    assign mm3_s = 1'b0;
    assign idx1_s = 5'd0;
    assign idx3_s = 5'd0;
`endif

    always @(negedge clk) begin
        mon_one(1'b0, if1.busy, if1.done, {if1.a, if1.b, if1.c, if1.d, if1.e},
                if1.truth_table, if1.ones_count, mm1_s, idx1_s);
        mon_one(1'b1, if3.busy, if3.done, {if3.a, if3.b, if3.c, if3.d, if3.e},
                if3.truth_table, if3.ones_count, mm3_s, idx3_s);
    end

    task automatic check_idle1(input string tag);
        check_val({tag, "_vec"}, {59'd0, if1.a, if1.b, if1.c, if1.d, if1.e}, 64'd0);
        check_val({tag, "_busy"}, {63'd0, if1.busy}, 64'd0);
        check_val({tag, "_done"}, {63'd0, if1.done}, 64'd0);
        check_val({tag, "_tt"}, {32'd0, if1.truth_table}, 64'd0);
        check_val({tag, "_ones"}, {58'd0, if1.ones_count}, 64'd0);
`ifdef CF_SWEEP_CHECK_EN
        check_val({tag, "_mm"}, {63'd0, if1.mismatch}, 64'd0);
`endif
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (((rq1.size() + rq3.size()) != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_val("drain_results", 64'(rq1.size() + rq3.size()), 64'd0);
        check_val("drain_vectors", 64'(vq1.size() + vq3.size()), 64'd0);
    endtask

    task automatic run_sweep1(input logic [31:0] fn);
        fn1 = fn;
        if1.start = 1'b1;
        push_sweep(1'b0, fn, cyc + 1);
        @(negedge clk);
        if1.start = 1'b0;
        wait_drain(200);
    endtask

    initial begin
        int e0;
        if1.start = 1'b0;
        if3.start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle1("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep1(GOLD);
        run_sweep1(32'd0);
        run_sweep1(GOLD ^ 32'h0000_0020);

        // S=3 sweep on the second instance
        if3.start = 1'b1;
        push_sweep(1'b1, GOLD, cyc + 1);
        @(negedge clk);
        if3.start = 1'b0;
        wait_drain(400);

        // start re-pulsed mid-sweep is ignored
        fn1 = GOLD;
        e0 = cyc + 1;
        if1.start = 1'b1;
        push_sweep(1'b0, GOLD, e0);
        @(negedge clk);
        if1.start = 1'b0;
        while (cyc < e0 + 10) @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_drain(200);

        // start held high: back-to-back restart with cleared results
        fn1 = GOLD;
        e0 = cyc + 1;
        if1.start = 1'b1;
        push_sweep(1'b0, GOLD, e0);
        push_sweep(1'b0, 32'h0000_0001, e0 + 33);
        while (cyc < e0 + 32) @(negedge clk);
        fn1 = 32'h0000_0001;
        @(negedge clk);
        check_val("restart_tt_clear", {32'd0, if1.truth_table}, 64'd0);
        check_val("restart_ones_clear", {58'd0, if1.ones_count}, 64'd0);
        check_val("restart_busy", {63'd0, if1.busy}, 64'd1);
        while (cyc < e0 + 40) @(negedge clk);
        if1.start = 1'b0;
        wait_drain(200);

        // asynchronous reset 15 cycles into a sweep
        fn1 = GOLD;
        e0 = cyc + 1;
        if1.start = 1'b1;
        push_sweep(1'b0, GOLD, e0);
        @(negedge clk);
        if1.start = 1'b0;
        while (cyc < e0 + 15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        rq1.delete();
        vq1.delete();
        #1;
        check_idle1("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_sweep1(GOLD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
